// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, FSM and ALU enums, and the instruction decoder
// used by the multi-cycle MIPS core.
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_e;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL} alu_op_e;

  // Instruction class: selects which path the FSM takes after EX
  typedef enum logic [3:0] {
    K_ALU, K_LOAD, K_STORE, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_JALR, K_ILLEGAL
  } kind_e;

  typedef struct packed {
    kind_e   kind;
    alu_op_e alu_op;
    logic    use_imm;   // ALU B operand is the immediate rather than Rt
    logic    zext_imm;  // immediate is zero-extended (andi/ori)
    logic    wr_rd;     // result goes to Rd (R-type) rather than Rt
  } decode_t;

  function automatic decode_t decode(input logic [31:0] ir);
    decode_t d;
    d.kind     = K_ILLEGAL;
    d.alu_op   = ALU_ADD;
    d.use_imm  = 1'b0;
    d.zext_imm = 1'b0;
    d.wr_rd    = 1'b0;
    case (ir[31:26])
      OP_RTYPE: begin
        d.wr_rd = 1'b1;
        case (ir[5:0])
          FN_ADD:  begin d.kind = K_ALU; d.alu_op = ALU_ADD; end
          FN_SUB:  begin d.kind = K_ALU; d.alu_op = ALU_SUB; end
          FN_AND:  begin d.kind = K_ALU; d.alu_op = ALU_AND; end
          FN_OR:   begin d.kind = K_ALU; d.alu_op = ALU_OR;  end
          FN_SLT:  begin d.kind = K_ALU; d.alu_op = ALU_SLT; end
          FN_SLL:  begin d.kind = K_ALU; d.alu_op = ALU_SLL; end
          FN_SRL:  begin d.kind = K_ALU; d.alu_op = ALU_SRL; end
          FN_JR:   d.kind = K_JR;
          FN_JALR: d.kind = K_JALR;
          default: d.kind = K_ILLEGAL;
        endcase
      end
      OP_ADDI: begin d.kind = K_ALU;   d.alu_op = ALU_ADD; d.use_imm = 1'b1; end
      OP_SLTI: begin d.kind = K_ALU;   d.alu_op = ALU_SLT; d.use_imm = 1'b1; end
      OP_ANDI: begin d.kind = K_ALU;   d.alu_op = ALU_AND; d.use_imm = 1'b1; d.zext_imm = 1'b1; end
      OP_ORI:  begin d.kind = K_ALU;   d.alu_op = ALU_OR;  d.use_imm = 1'b1; d.zext_imm = 1'b1; end
      OP_LW:   begin d.kind = K_LOAD;  d.alu_op = ALU_ADD; d.use_imm = 1'b1; end
      OP_SW:   begin d.kind = K_STORE; d.alu_op = ALU_ADD; d.use_imm = 1'b1; end
      OP_BEQ:  begin d.kind = K_BEQ;   d.alu_op = ALU_SUB; end
      OP_BNE:  begin d.kind = K_BNE;   d.alu_op = ALU_SUB; end
      OP_J:    d.kind = K_J;
      OP_JAL:  d.kind = K_JAL;
      default: d.kind = K_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU: arithmetic, logic, signed compare and logical shifts.
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  alu_op_e     alu_op,
  output logic [31:0] result,
  output logic        zero
);

  // Operation select; shifts act on b by the instruction's shamt field
  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLL: result = b << shamt;
      ALU_SRL: result = b >> shamt;
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/multicycle_mips.sv
// Multi-cycle MIPS core: IF/ID/EX/MEM/WB/HALT sequencing with ready handshakes
// on instruction and data memories, a 32-entry register file with $0 tied low.
module multicycle_mips
  import mips_pkg::*;
#(
  parameter int          DMEM_AW         = 7,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  output logic [31:0]        IR_addr,
  output logic               IR_req,
  input  logic [31:0]        IR,
  input  logic               IR_ready,
  output logic [DMEM_AW-1:0] A,
  output logic [31:0]        Data2Mem,
  input  logic [31:0]        ReadDataMem,
  output logic               CEN,
  output logic               OEN,
  output logic               WEN,
  input  logic               DMem_ready,
  output logic               halt
);

  state_e      state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic [31:0] ir_q;
  logic [31:0] a_q, b_q;
  logic [31:0] alu_q;
  logic [31:0] mdr_q;
  logic [31:0] rf_q [32];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  // Instruction fields of the latched instruction
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  decode_t     dec;

  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign shamt = ir_q[10:6];
  assign imm16 = ir_q[15:0];
  assign jaddr = ir_q[25:0];
  assign dec   = decode(ir_q);

  logic [31:0] imm_ext, alu_b, alu_result, link;
  logic        alu_zero;
  logic [29:0] pc_plus4, br_target, j_target;

  assign imm_ext   = dec.zext_imm ? {16'b0, imm16} : {{16{imm16[15]}}, imm16};
  assign alu_b     = dec.use_imm ? imm_ext : b_q;
  assign pc_plus4  = pc_q + 30'd1;
  assign br_target = pc_plus4 + {{14{imm16[15]}}, imm16};
  assign j_target  = {pc_plus4[29:26], jaddr};
  assign link      = {pc_plus4, 2'b00};

  mips_alu u_alu (
    .a      (a_q),
    .b      (alu_b),
    .shamt  (shamt),
    .alu_op (dec.alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Next state, PC update, register write and memory strobes
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = alu_q;
    IR_req   = 1'b0;
    OEN      = 1'b1;
    WEN      = 1'b1;
    halt     = 1'b0;
    case (state_q)
      S_IF: begin
        // Held low during reset so a reset cycle never looks like a fetch
        IR_req = !rst;
        if (IR_ready) state_d = S_ID;
      end
      S_ID: begin
        if (dec.kind == K_ILLEGAL) begin
          if (HALT_ON_ILLEGAL) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_plus4;
            state_d = S_IF;
          end
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        state_d = S_IF;
        case (dec.kind)
          K_BEQ: pc_d = alu_zero ? br_target : pc_plus4;
          K_BNE: pc_d = alu_zero ? pc_plus4 : br_target;
          K_J:   pc_d = j_target;
          K_JAL: begin
            pc_d     = j_target;
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = link;
          end
          K_JR:  pc_d = a_q[31:2];
          K_JALR: begin
            pc_d     = a_q[31:2];
            rf_we    = 1'b1;
            rf_waddr = rd;
            rf_wdata = link;
          end
          K_LOAD, K_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dec.kind == K_LOAD) OEN = 1'b0;
        else                    WEN = 1'b0;
        if (DMem_ready) begin
          if (dec.kind == K_LOAD) begin
            state_d = S_WB;
          end else begin
            pc_d    = pc_plus4;
            state_d = S_IF;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = (dec.wr_rd && dec.kind != K_LOAD) ? rd : rt;
        rf_wdata = (dec.kind == K_LOAD) ? mdr_q : alu_q;
        pc_d     = pc_plus4;
        state_d  = S_IF;
      end
      S_HALT: halt = 1'b1;
      default: state_d = S_IF;
    endcase
  end

  // FSM state register; reset abandons any pending memory access
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  // Datapath latches, each loaded only in the state that produces its value
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC[31:2];
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      alu_q <= '0;
      mdr_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (state_q == S_IF && IR_ready) ir_q <= IR;
      if (state_q == S_ID) begin
        a_q <= rf_q[rs];
        b_q <= rf_q[rt];
      end
      if (state_q == S_EX) alu_q <= alu_result;
      if (state_q == S_MEM && DMem_ready) mdr_q <= ReadDataMem;
    end
  end

  // Register file; entry 0 is never written so it always reads zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign IR_addr  = {pc_q, 2'b00};
  assign A        = alu_q[DMEM_AW+1:2];
  assign Data2Mem = b_q;
  assign CEN      = OEN & WEN;

endmodule

// File: tb/tb_multicycle_mips.sv
// Self-checking bench for multicycle_mips: program in a behavioural instruction
// memory, variable-latency data SRAM model, store scoreboard and control checks.
module tb_multicycle_mips;

  localparam logic [5:0] T_RTYPE = 6'h00, T_J = 6'h02, T_JAL = 6'h03, T_BEQ = 6'h04;
  localparam logic [5:0] T_BNE = 6'h05, T_ADDI = 6'h08, T_SLTI = 6'h0A, T_ANDI = 6'h0C;
  localparam logic [5:0] T_ORI = 6'h0D, T_LW = 6'h23, T_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_JALR = 6'h09;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
  localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IR_addr, IR, Data2Mem, ReadDataMem;
  logic        IR_req, IR_ready, CEN, OEN, WEN, DMem_ready, halt;
  logic [6:0]  A;

  logic [31:0] imem [512];
  logic [31:0] dmem [128];
  int          imem_wait, dmem_wait;
  int          f_cnt = 0, d_cnt = 0;
  int          checks = 0, errors = 0;
  logic        seen_400 = 1'b0;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
  } store_t;
  store_t sb_q [$];

  multicycle_mips #(.DMEM_AW(7), .RESET_PC(32'h40), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst),
    .IR_addr(IR_addr), .IR_req(IR_req), .IR(IR), .IR_ready(IR_ready),
    .A(A), .Data2Mem(Data2Mem), .ReadDataMem(ReadDataMem),
    .CEN(CEN), .OEN(OEN), .WEN(WEN), .DMem_ready(DMem_ready), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh);
    return {T_RTYPE, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] ad);
    return {op, ad};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    imem[addr[10:2]] = word;
  endtask
  task automatic expect_store(input logic [6:0] a, input logic [31:0] d);
    sb_q.push_back({a, d});
  endtask

  // Memory models: ready after a programmable number of wait cycles
  assign IR          = imem[IR_addr[10:2]];
  assign IR_ready    = IR_req && (f_cnt >= imem_wait);
  assign ReadDataMem = dmem[A];
  assign DMem_ready  = !CEN && (d_cnt >= dmem_wait);

  always @(posedge clk) begin
    if (IR_req && !IR_ready) f_cnt <= f_cnt + 1; else f_cnt <= 0;
    if (!CEN && !DMem_ready) d_cnt <= d_cnt + 1; else d_cnt <= 0;
    if (!WEN && DMem_ready) dmem[A] <= Data2Mem;
  end

  // Scoreboard: each completed store is compared against the next expected one
  always @(negedge clk) begin
    if (!rst && !WEN && DMem_ready) begin
      $display("store A=%0d data=%h", A, Data2Mem);
      check_eq("sb_nonempty", {31'b0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        check_eq("st_addr", {25'b0, A}, {25'b0, sb_q[0].addr});
        check_eq("st_data", Data2Mem, sb_q[0].data);
        sb_q.delete(0);
      end
    end
    if (IR_req && IR_addr == 32'h400) seen_400 <= 1'b1;
  end

  initial begin
    int n, hold;
    logic req_seen;
    rst = 1'b1; imem_wait = 0; dmem_wait = 3;
    for (int i = 0; i < 512; i++) imem[i] = ILLEGAL;
    for (int i = 0; i < 128; i++) dmem[i] = 32'h0;

    put(32'h40, itype(T_ADDI, 0, 1, 16'd5));
    put(32'h44, rtype(F_ADD, 1, 1, 2, 0));
    put(32'h48, itype(T_ADDI, 0, 0, 16'd7));
    put(32'h4C, itype(T_SW, 0, 2, 16'd4));        expect_store(7'd1, 32'd10);
    put(32'h50, itype(T_LW, 0, 3, 16'd4));
    put(32'h54, itype(T_SW, 0, 0, 16'd8));        expect_store(7'd2, 32'd0);
    put(32'h58, itype(T_SW, 0, 3, 16'd12));       expect_store(7'd3, 32'd10);
    put(32'h5C, rtype(F_SUB, 1, 2, 4, 0));
    put(32'h60, rtype(F_SLT, 4, 1, 5, 0));
    put(32'h64, rtype(F_SLL, 0, 1, 6, 4));
    put(32'h68, rtype(F_SRL, 0, 4, 7, 28));
    put(32'h6C, itype(T_ANDI, 4, 8, 16'hFF00));
    put(32'h70, itype(T_ORI, 0, 9, 16'h8001));
    put(32'h74, itype(T_SLTI, 4, 10, 16'hFFFC));
    put(32'h78, rtype(F_AND, 4, 9, 11, 0));
    put(32'h7C, rtype(F_OR, 6, 7, 12, 0));
    put(32'h80, itype(T_SW, 0, 4, 16'd16));       expect_store(7'd4, 32'hFFFF_FFFB);
    put(32'h84, itype(T_SW, 0, 5, 16'd20));       expect_store(7'd5, 32'd1);
    put(32'h88, itype(T_SW, 0, 6, 16'd24));       expect_store(7'd6, 32'h50);
    put(32'h8C, itype(T_SW, 0, 7, 16'd28));       expect_store(7'd7, 32'hF);
    put(32'h90, itype(T_SW, 0, 8, 16'd32));       expect_store(7'd8, 32'hFF00);
    put(32'h94, itype(T_SW, 0, 9, 16'd36));       expect_store(7'd9, 32'h8001);
    put(32'h98, itype(T_SW, 0, 10, 16'd40));      expect_store(7'd10, 32'd1);
    put(32'h9C, itype(T_SW, 0, 11, 16'd44));      expect_store(7'd11, 32'h8001);
    put(32'hA0, itype(T_SW, 0, 12, 16'd48));      expect_store(7'd12, 32'h5F);
    put(32'hA4, itype(T_BEQ, 1, 1, 16'hFFFF));
    put(32'hA8, jtype(T_J, 26'h8));
    put(32'h20, jtype(T_JAL, 26'h100));
    put(32'h400, itype(T_SW, 0, 31, 16'd52));     expect_store(7'd13, 32'h24);
    put(32'h404, rtype(F_JR, 31, 0, 0, 0));
    put(32'h24, itype(T_ADDI, 0, 14, 16'h30));
    put(32'h28, rtype(F_JALR, 14, 0, 13, 0));
    put(32'h30, itype(T_SW, 0, 13, 16'd56));      expect_store(7'd14, 32'h2C);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_IR_req", {31'b0, IR_req}, 32'd0);
    check_eq("rst_OEN", {31'b0, OEN}, 32'd1);
    check_eq("rst_WEN", {31'b0, WEN}, 32'd1);
    check_eq("rst_CEN", {31'b0, CEN}, 32'd1);
    check_eq("rst_halt", {31'b0, halt}, 32'd0);
    check_eq("rst_A", {25'b0, A}, 32'd0);
    check_eq("rst_Data2Mem", Data2Mem, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("boot_IR_req", {31'b0, IR_req}, 32'd1);
    check_eq("boot_IR_addr", IR_addr, 32'h40);

    // Two zero-wait ALU instructions take 8 cycles
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_eq("alu_cpi_addr", IR_addr, 32'h48);
    check_eq("alu_cpi_req", {31'b0, IR_req}, 32'd1);

    // Store with three wait cycles holds the write strobe for four cycles
    n = 0;
    while (WEN && n < 100) begin @(negedge clk); n++; end
    check_eq("sw_started", {31'b0, WEN}, 32'd0);
    check_eq("sw_wait_A", {25'b0, A}, 32'd1);
    check_eq("sw_wait_data", Data2Mem, 32'd10);
    hold = 0;
    while (!WEN && hold < 20) begin @(negedge clk); hold++; end
    check_eq("sw_hold_cycles", hold, 32'd4);
    dmem_wait = 0;

    // beq to itself: 3 cycles per iteration, then patched to a falling-through bne
    n = 0;
    while (!(IR_req && IR_addr == 32'hA4) && n < 2000) begin @(negedge clk); n++; end
    check_eq("beq_reached", IR_addr, 32'hA4);
    for (int it = 0; it < 2; it++) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("beq_loop_addr", IR_addr, 32'hA4);
      check_eq("beq_loop_req", {31'b0, IR_req}, 32'd1);
    end
    put(32'hA4, itype(T_BNE, 1, 1, 16'hFFFF));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("bne_fallthru", IR_addr, 32'hA8);
    imem_wait = 1;

    // Jumps and links, then the illegal opcode halts the core
    n = 0;
    while (halt !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check_eq("halt_set", {31'b0, halt}, 32'd1);
    req_seen = 1'b0;
    repeat (10) begin @(negedge clk); if (IR_req) req_seen = 1'b1; end
    check_eq("halt_no_req", {31'b0, req_seen}, 32'd0);
    check_eq("halt_sticky", {31'b0, halt}, 32'd1);
    check_eq("jal_target_fetched", {31'b0, seen_400}, 32'd1);
    check_eq("sb_drained", sb_q.size(), 32'd0);

    // Reset out of HALT
    rst = 1'b1; imem_wait = 0; dmem_wait = 50;
    @(posedge clk);
    @(negedge clk);
    check_eq("hrst_halt", {31'b0, halt}, 32'd0);
    check_eq("hrst_OEN", {31'b0, OEN}, 32'd1);
    check_eq("hrst_WEN", {31'b0, WEN}, 32'd1);
    rst = 1'b0;
    #1;
    check_eq("hrst_IR_req", {31'b0, IR_req}, 32'd1);
    check_eq("hrst_IR_addr", IR_addr, 32'h40);

    // Reset in the middle of a stalled store
    n = 0;
    while (WEN && n < 100) begin @(negedge clk); n++; end
    check_eq("mrst_sw_started", {31'b0, WEN}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("mrst_WEN", {31'b0, WEN}, 32'd1);
    check_eq("mrst_OEN", {31'b0, OEN}, 32'd1);
    check_eq("mrst_CEN", {31'b0, CEN}, 32'd1);
    check_eq("mrst_halt", {31'b0, halt}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("mrst_IR_addr", IR_addr, 32'h40);
    check_eq("mrst_IR_req", {31'b0, IR_req}, 32'd1);
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
